sccb_arbiter: RTL and testbench



---
 rtl/sccb_arbiter.sv | 179 +++++++++++++++++
 tb/tb_sccb_arbiter.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sccb_arbiter.sv
// sccb_arbiter
//   Shares one SCCB_interface write port among NUM_REQ requesters (for
//   example a ROM-driven camera config sequencer and a runtime exposure/gain
//   writer). Requests are granted round-robin. The winner's register
//   address/data are forwarded with a start request. The interface's ready
//   drop and rise are tracked, and a one-cycle ack (or err on timeout) goes
//   back to the granted requester.
//
//   Optional feature macro: SCCB_ARB_TIMEOUT_EN
//     defined   : each wait state aborts after TIMEOUT_CYCLES enabled cycles
//                 and pulses err[grant_id]
//     undefined : no timer; err is tied 0; waits on ready are unbounded
//
// Ports
//   clk, rst, clk_en      clock, synchronous active-high reset, clock enable
//   req[NUM_REQ]          level requests, held until ack/err
//   req_addr/req_data     8-bit address/data per requester, slice i at [8i+7:8i]
//   ack/err[NUM_REQ]      one-enabled-cycle completion / abort pulses
//   grant_id              index of the current or last grant
//   busy                  high whenever the arbiter is not idle
//   SCCB_interface_*      ready in; addr, data, start out
module sccb_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int CLK_FREQ       = 25000000,
    parameter int TIMEOUT_CYCLES = CLK_FREQ / 1000
) (
    input  logic                                           clk,
    input  logic                                           rst,
    input  logic                                           clk_en,
    input  logic [NUM_REQ-1:0]                             req,
    input  logic [NUM_REQ*8-1:0]                           req_addr,
    input  logic [NUM_REQ*8-1:0]                           req_data,
    output logic [NUM_REQ-1:0]                             ack,
    output logic [NUM_REQ-1:0]                             err,
    output logic [(NUM_REQ > 1 ? $clog2(NUM_REQ) : 1)-1:0] grant_id,
    output logic                                           busy,
    input  logic                                           SCCB_interface_ready,
    output logic [7:0]                                     SCCB_interface_addr,
    output logic [7:0]                                     SCCB_interface_data,
    output logic                                           SCCB_interface_start
);
    localparam int          GW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [GW:0] NUM_REQ_W = (GW + 1)'(NUM_REQ);
    localparam logic [GW:0] ONE_W     = (GW + 1)'(1);

    typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_DONE, RELEASE} state_t;

    state_t              state_reg;
    logic [GW-1:0]       grant_reg;
    logic [GW-1:0]       last_grant_reg;
    logic [7:0]          addr_reg;
    logic [7:0]          data_reg;
    logic                start_reg;
    logic [NUM_REQ-1:0]  ack_reg;

`ifdef SCCB_ARB_TIMEOUT_EN
    localparam int          TW         = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TW-1:0] TIMER_LOAD = TW'(TIMEOUT_CYCLES);
    logic [TW-1:0]       timer_reg;
    logic [NUM_REQ-1:0]  err_reg;
`endif

    // Round-robin winner: rotate the request vector so that bit 0 is the
    // requester just after last_grant, take the lowest set bit, then rotate
    // the offset back. Doubling req makes the rotate a plain right shift.
    logic [2*NUM_REQ-1:0] req_twice;
    logic [NUM_REQ-1:0]   req_rot;
    logic [GW:0]          rot_amount;
    logic [GW-1:0]        offset_chain [NUM_REQ+1];
    logic [GW:0]          winner_sum;
    logic [GW-1:0]        winner_next;
    logic [7:0]           addr_slice [NUM_REQ];
    logic [7:0]           data_slice [NUM_REQ];

    assign req_twice              = {req, req};
    assign rot_amount             = {1'b0, last_grant_reg} + ONE_W;
    assign req_rot                = NUM_REQ'(req_twice >> rot_amount);
    assign offset_chain[NUM_REQ]  = '0;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
            // Lower offsets override higher ones: first set bit wins.
            assign offset_chain[gi] = req_rot[gi] ? GW'(gi) : offset_chain[gi+1];
            assign addr_slice[gi]   = req_addr[8*gi +: 8];
            assign data_slice[gi]   = req_data[8*gi +: 8];
        end
    endgenerate

    assign winner_sum  = rot_amount + {1'b0, offset_chain[0]};
    assign winner_next = (winner_sum >= NUM_REQ_W) ? GW'(winner_sum - NUM_REQ_W)
                                                   : winner_sum[GW-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            grant_reg      <= '0;
            last_grant_reg <= GW'(NUM_REQ - 1);
            addr_reg       <= '0;
            data_reg       <= '0;
            start_reg      <= 1'b0;
            ack_reg        <= '0;
`ifdef SCCB_ARB_TIMEOUT_EN
            err_reg        <= '0;
            timer_reg      <= '0;
`endif
        end else if (clk_en) begin
            ack_reg <= '0;
`ifdef SCCB_ARB_TIMEOUT_EN
            err_reg <= '0;
`endif
            case (state_reg)
                IDLE: begin
                    if (|req && SCCB_interface_ready) begin
                        grant_reg <= winner_next;
                        addr_reg  <= addr_slice[winner_next];
                        data_reg  <= data_slice[winner_next];
                        start_reg <= 1'b1;
`ifdef SCCB_ARB_TIMEOUT_EN
                        timer_reg <= TIMER_LOAD;
`endif
                        state_reg <= WAIT_BUSY;
                    end
                end
                WAIT_BUSY: begin
                    // The ready drop wins over a simultaneous timer expiry.
                    if (!SCCB_interface_ready) begin
                        start_reg <= 1'b0;
`ifdef SCCB_ARB_TIMEOUT_EN
                        timer_reg <= TIMER_LOAD;
`endif
                        state_reg <= WAIT_DONE;
                    end
`ifdef SCCB_ARB_TIMEOUT_EN
                    else if (timer_reg == '0) begin
                        start_reg          <= 1'b0;
                        err_reg[grant_reg] <= 1'b1;
                        state_reg          <= RELEASE;
                    end else begin
                        timer_reg <= timer_reg - TW'(1);
                    end
`endif
                end
                WAIT_DONE: begin
                    if (SCCB_interface_ready) begin
                        ack_reg[grant_reg] <= 1'b1;
                        state_reg          <= RELEASE;
                    end
`ifdef SCCB_ARB_TIMEOUT_EN
                    else if (timer_reg == '0) begin
                        err_reg[grant_reg] <= 1'b1;
                        state_reg          <= RELEASE;
                    end else begin
                        timer_reg <= timer_reg - TW'(1);
                    end
`endif
                end
                RELEASE: begin
                    // One cycle for the requester to drop req after ack/err.
                    last_grant_reg <= grant_reg;
                    state_reg      <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign ack                  = ack_reg;
`ifdef SCCB_ARB_TIMEOUT_EN
    assign err                  = err_reg;
`else
    assign err                  = '0;
`endif
    assign grant_id             = grant_reg;
    assign busy                 = (state_reg != IDLE);
    assign SCCB_interface_addr  = addr_reg;
    assign SCCB_interface_data  = data_reg;
    assign SCCB_interface_start = start_reg;

endmodule

// File: tb/tb_sccb_arbiter.sv
// Testbench for sccb_arbiter: table-driven transactions, hand-written corner
// sequences (hold-off, clk_en gating, mid-transaction changes, reset, and
// timeouts when SCCB_ARB_TIMEOUT_EN is defined), and a randomized run against
// a transaction-level round-robin model with per-requester write queues.
module tb_sccb_arbiter;
    localparam int N  = 3;
    localparam int GW = 2;
    localparam int TO = 8;
    localparam int QD = 12;

    logic             clk = 1'b0;
    logic             rst;
    logic             clk_en;
    logic [N-1:0]     req;
    logic [N*8-1:0]   req_addr;
    logic [N*8-1:0]   req_data;
    logic [N-1:0]     ack;
    logic [N-1:0]     err;
    logic [GW-1:0]    grant_id;
    logic             busy;
    logic             ready;
    logic [7:0]       ifc_addr;
    logic [7:0]       ifc_data;
    logic             ifc_start;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    sccb_arbiter #(
        .NUM_REQ        (N),
        .CLK_FREQ       (8000),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .clk_en               (clk_en),
        .req                  (req),
        .req_addr             (req_addr),
        .req_data             (req_data),
        .ack                  (ack),
        .err                  (err),
        .grant_id             (grant_id),
        .busy                 (busy),
        .SCCB_interface_ready (ready),
        .SCCB_interface_addr  (ifc_addr),
        .SCCB_interface_data  (ifc_data),
        .SCCB_interface_start (ifc_start)
    );

    typedef struct {
        logic [N-1:0] req;
        int           d1;
        int           d2;
        int           exp_g;
    } vec_t;

    vec_t vt [11];

    // random-run state
    int           n_it [N];
    int           hd [N];
    int           join_at [N];
    logic [7:0]   qa [N][QD];
    logic [7:0]   qd [N][QD];
    int           last_m, cur, phase, dcnt, remaining, cyc, exp_w;
    logic [N-1:0] drop, req_s;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] snap();
        return 64'({ack, err, grant_id, busy, ifc_start, ifc_addr, ifc_data});
    endfunction

    // One enabled cycle; when gated, three disabled cycles come first and
    // every output must hold through them.
    task automatic step(input bit gated);
        if (gated) begin
            logic [63:0] s;
            s = snap();
            clk_en = 1'b0;
            repeat (3) begin
                tick();
                check("hold_clk_en_low", snap(), s);
            end
            clk_en = 1'b1;
        end
        tick();
    endtask

    function automatic logic [7:0] pa(input int v, input int i);
        return 8'(16 * v + i + 1);
    endfunction

    function automatic logic [7:0] pd(input int v, input int i);
        return 8'(128 + 5 * v + 7 * i);
    endfunction

    task automatic set_payload(input int v);
        for (int i = 0; i < N; i++) begin
            req_addr[8*i +: 8] = pa(v, i);
            req_data[8*i +: 8] = pd(v, i);
        end
    endtask

    // Round-robin rule: first set request scanning upward from last+1.
    function automatic int rr(input int last, input logic [N-1:0] r);
        for (int k = 1; k <= N; k++)
            if (r[(last + k) % N]) return (last + k) % N;
        return -1;
    endfunction

    task automatic do_txn(input int v, input logic [N-1:0] mask, input int d1,
                          input int d2, input int exp_g, input bit gated);
        set_payload(v);
        req = mask;
        step(gated);
        check($sformatf("v%0d_grant", v), 64'(grant_id), 64'(exp_g));
        check($sformatf("v%0d_start", v), 64'(ifc_start), 64'(1));
        check($sformatf("v%0d_addr", v), 64'(ifc_addr), 64'(pa(v, exp_g)));
        check($sformatf("v%0d_data", v), 64'(ifc_data), 64'(pd(v, exp_g)));
        check($sformatf("v%0d_busy", v), 64'(busy), 64'(1));
        for (int k = 0; k < d1; k++) begin
            step(gated);
            check($sformatf("v%0d_start_hold", v), 64'(ifc_start), 64'(1));
        end
        ready = 1'b0;
        step(gated);
        check($sformatf("v%0d_start_drop", v), 64'(ifc_start), 64'(0));
        for (int k = 0; k < d2; k++) begin
            step(gated);
            check($sformatf("v%0d_no_early_ack", v), 64'(ack), 64'(0));
        end
        ready = 1'b1;
        step(gated);
        check($sformatf("v%0d_ack", v), 64'(ack), 64'(1) << exp_g);
        check($sformatf("v%0d_err", v), 64'(err), 64'(0));
        req = '0;
        step(gated);
        check($sformatf("v%0d_ack_one_cycle", v), 64'(ack), 64'(0));
        check($sformatf("v%0d_idle", v), 64'(busy), 64'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0]  = '{3'b001, 0, 2, 0};
        vt[1]  = '{3'b011, 1, 3, 1};
        vt[2]  = '{3'b011, 2, 0, 0};
        vt[3]  = '{3'b110, 0, 1, 1};
        vt[4]  = '{3'b110, 3, 4, 2};
        vt[5]  = '{3'b101, 1, 1, 0};
        vt[6]  = '{3'b100, 0, 5, 2};
        vt[7]  = '{3'b111, 2, 2, 0};
        vt[8]  = '{3'b111, 1, 0, 1};
        vt[9]  = '{3'b010, 0, 3, 1};
        vt[10] = '{3'b111, 3, 1, 2};

        rst = 1'b1; clk_en = 1'b1; req = '0; ready = 1'b1;
        req_addr = '0; req_data = '0;
        tick(); tick();
        check("reset_outputs", snap(), 64'(0));
        rst = 1'b0;

        // table-driven transactions
        for (int v = 0; v < 11; v++)
            do_txn(v, vt[v].req, vt[v].d1, vt[v].d2, vt[v].exp_g, 1'b0);

        // not-ready hold-off: request pending while the interface is busy
        ready = 1'b0; req = 3'b010; set_payload(20);
        for (int k = 0; k < 50; k++) begin
            tick();
            check("holdoff_start", 64'(ifc_start), 64'(0));
            check("holdoff_busy", 64'(busy), 64'(0));
        end
        ready = 1'b1;
        tick();
        check("holdoff_start_after_ready", 64'(ifc_start), 64'(1));
        check("holdoff_grant", 64'(grant_id), 64'(1));
        check("holdoff_addr", 64'(ifc_addr), 64'(pa(20, 1)));
        ready = 1'b0; tick();
        ready = 1'b1; tick();
        check("holdoff_ack", 64'(ack), 64'(3'b010));
        req = '0; tick();

        // clk_en gating: same sequence stretched by disabled cycles
        do_txn(21, 3'b101, 1, 2, 2, 1'b1);

        // request side changes mid-transaction are ignored; drop keeps the ack
        set_payload(22); req = 3'b001;
        tick();
        check("mid_grant", 64'(grant_id), 64'(0));
        set_payload(23); req = '0;
        tick();
        check("mid_start_held", 64'(ifc_start), 64'(1));
        check("mid_addr_held", 64'(ifc_addr), 64'(pa(22, 0)));
        check("mid_data_held", 64'(ifc_data), 64'(pd(22, 0)));
        ready = 1'b0; tick();
        ready = 1'b1; tick();
        check("mid_drop_still_acked", 64'(ack), 64'(3'b001));
        tick();

        // reset in WAIT_DONE, with clk_en low to show reset priority
        set_payload(24); req = 3'b010;
        tick();
        check("rst_pre_grant", 64'(grant_id), 64'(1));
        ready = 1'b0; tick();
        check("rst_in_wait_done", 64'(busy), 64'(1));
        rst = 1'b1; clk_en = 1'b0;
        tick();
        check("rst_mid_outputs", snap(), 64'(0));
        rst = 1'b0; clk_en = 1'b1; ready = 1'b1; req = '0;
        tick();
        check("rst_no_ack", 64'(ack), 64'(0));
        check("rst_idle", 64'(busy), 64'(0));
        req = 3'b111; tick();
        check("rst_next_grant_req0", 64'(grant_id), 64'(0));
        ready = 1'b0; tick();
        ready = 1'b1; tick();
        check("rst_next_ack", 64'(ack), 64'(3'b001));
        req = '0; tick();

`ifdef SCCB_ARB_TIMEOUT_EN
        // WAIT_BUSY timeout: ready never drops
        req = 3'b100; tick();
        check("tob_grant", 64'(grant_id), 64'(2));
        for (int k = 0; k < TO; k++) begin
            tick();
            check("tob_start_held", 64'(ifc_start), 64'(1));
            check("tob_no_err", 64'(err), 64'(0));
        end
        tick();
        check("tob_start_off", 64'(ifc_start), 64'(0));
        check("tob_err", 64'(err), 64'(3'b100));
        check("tob_no_ack", 64'(ack), 64'(0));
        req = '0; tick();
        check("tob_err_one_cycle", 64'(err), 64'(0));
        check("tob_idle", 64'(busy), 64'(0));
        // WAIT_DONE timeout: ready never rises
        req = 3'b001; tick();
        check("tod_grant", 64'(grant_id), 64'(0));
        ready = 1'b0; tick();
        for (int k = 0; k < TO; k++) begin
            tick();
            check("tod_no_err", 64'(err), 64'(0));
        end
        tick();
        check("tod_err", 64'(err), 64'(3'b001));
        check("tod_no_ack", 64'(ack), 64'(0));
        req = '0; ready = 1'b1; tick();
        check("tod_err_one_cycle", 64'(err), 64'(0));
        // ready drop coinciding with timer==0 takes the ready path
        req = 3'b010; tick();
        check("tos_grant", 64'(grant_id), 64'(1));
        for (int k = 0; k < TO; k++) tick();
        ready = 1'b0; tick();
        check("tos_no_err", 64'(err), 64'(0));
        check("tos_start_off", 64'(ifc_start), 64'(0));
        check("tos_busy", 64'(busy), 64'(1));
        ready = 1'b1; tick();
        check("tos_ack", 64'(ack), 64'(3'b010));
        req = '0; tick();
`else
        // no timer: waits are unbounded and err never fires
        req = 3'b010; tick();
        check("nto_grant", 64'(grant_id), 64'(1));
        for (int k = 0; k < 20; k++) begin
            tick();
            check("nto_start_held", 64'(ifc_start), 64'(1));
            check("nto_no_err", 64'(err), 64'(0));
        end
        ready = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            check("nto_wait_no_ack", 64'(ack | err), 64'(0));
        end
        ready = 1'b1; tick();
        check("nto_ack", 64'(ack), 64'(3'b010));
        req = '0; tick();
`endif

        // randomized run against the queue-level model
        rst = 1'b1; req = '0; ready = 1'b1; tick(); tick(); rst = 1'b0;
        remaining = 0;
        for (int i = 0; i < N; i++) begin
            n_it[i]    = int'($urandom_range(4, QD));
            hd[i]      = 0;
            join_at[i] = int'($urandom_range(0, 40));
            for (int j = 0; j < QD; j++) begin
                qa[i][j] = 8'($urandom);
                qd[i][j] = 8'($urandom);
            end
            remaining += n_it[i];
        end
        last_m = N - 1; cur = 0; phase = 0; dcnt = 0; drop = '0; cyc = 0;
        while (remaining > 0 && cyc < 5000) begin
            for (int i = 0; i < N; i++) begin
                req[i] = (cyc >= join_at[i]) && (hd[i] < n_it[i]) && !drop[i];
                if (hd[i] < n_it[i]) begin
                    req_addr[8*i +: 8] = qa[i][hd[i]];
                    req_data[8*i +: 8] = qd[i][hd[i]];
                end
            end
            req_s = req;
            tick();
            cyc++;
            drop = '0;
            check("rnd_err", 64'(err), 64'(0));
            case (phase)
                0: begin
                    check("rnd_idle_ack", 64'(ack), 64'(0));
                    check("rnd_busy_vs_start", 64'(busy), 64'(ifc_start));
                    if (ifc_start) begin
                        exp_w = rr(last_m, req_s);
                        check("rnd_grant", 64'(grant_id), 64'(exp_w));
                        if (exp_w >= 0) begin
                            check("rnd_addr", 64'(ifc_addr), 64'(qa[exp_w][hd[exp_w]]));
                            check("rnd_data", 64'(ifc_data), 64'(qd[exp_w][hd[exp_w]]));
                            cur = exp_w;
                        end else begin
                            cur = int'(grant_id);
                        end
                        dcnt  = int'($urandom_range(0, 3));
                        phase = 1;
                    end
                end
                1: begin
                    check("rnd_start_held", 64'(ifc_start), 64'(1));
                    check("rnd_ack_wb", 64'(ack), 64'(0));
                    if (dcnt == 0) begin
                        ready = 1'b0;
                        dcnt  = int'($urandom_range(0, 5));
                        phase = 2;
                    end else dcnt--;
                end
                2: begin
                    check("rnd_start_off", 64'(ifc_start), 64'(0));
                    check("rnd_ack_wd", 64'(ack), 64'(0));
                    if (dcnt == 0) begin
                        ready = 1'b1;
                        phase = 3;
                    end else dcnt--;
                end
                default: begin
                    check("rnd_ack", 64'(ack), 64'(1) << cur);
                    check("rnd_busy_release", 64'(busy), 64'(1));
                    hd[cur]++;
                    remaining--;
                    last_m    = cur;
                    drop[cur] = 1'b1;
                    phase     = 0;
                end
            endcase
        end
        check("rnd_all_served", 64'(remaining), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
